// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with flop storage.
// One outstanding fetch; misses refill a whole line from a word-wide memory port.
module icache #(
    parameter int unsigned NUM_LINES    = 16,
    parameter int unsigned INDEX_WIDTH  = 4,
    parameter int unsigned LINE_WORDS   = 4,
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_req_valid,
    output logic        icache_req_ready,
    input  logic [31:0] fetch_address,
    output logic        icache_resp_valid,
    input  logic        icache_resp_ready,
    output logic [31:0] fetch_data,
    output logic [31:0] icache_resp_address,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int unsigned LINE_LSB = 2 + OFFSET_WIDTH;
    localparam int unsigned TAG_LSB  = LINE_LSB + INDEX_WIDTH;
    localparam int unsigned TAG_W    = 32 - TAG_LSB;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [NUM_LINES-1:0]    valid;
    logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
    logic [31:0]             data_mem [NUM_LINES][LINE_WORDS];

    logic [31:0]             req_addr;
    logic [OFFSET_WIDTH-1:0] cnt;
    logic                    inv_pend;

    logic [INDEX_WIDTH-1:0]  idx;
    logic [OFFSET_WIDTH-1:0] off;
    logic [TAG_W-1:0]        req_tag;
    logic                    hit;
    logic                    last_beat;
    logic [31:0]             resp_word;

    assign idx       = req_addr[LINE_LSB +: INDEX_WIDTH];
    assign off       = req_addr[2 +: OFFSET_WIDTH];
    assign req_tag   = req_addr[31:TAG_LSB];
    assign hit       = valid[idx] && (tag_mem[idx] == req_tag);
    assign last_beat = (state == REFILL) && mem_resp_valid
                       && (cnt == OFFSET_WIDTH'(LINE_WORDS - 1));

    // The requested word may arrive on the install beat itself, so bypass it.
    always_comb begin
        resp_word = data_mem[idx][off];
        if (state == REFILL && off == cnt) begin
            resp_word = mem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (icache_req_valid) state_nx = LOOKUP;
            LOOKUP:   state_nx = hit ? RESP : MISS_REQ;
            MISS_REQ: if (mem_req_ready) state_nx = REFILL;
            REFILL:   if (last_beat) state_nx = RESP;
            RESP:     if (icache_resp_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Control state and valid bits; invalidate is applied last so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            req_addr <= '0;
            cnt      <= '0;
            inv_pend <= 1'b0;
        end else begin
            if (state == IDLE && icache_req_valid) begin
                req_addr <= fetch_address;
            end
            if (state == LOOKUP && !hit) begin
                inv_pend <= 1'b0;
            end
            if (state == MISS_REQ && mem_req_ready) begin
                cnt <= '0;
            end
            if (state == REFILL && mem_resp_valid) begin
                cnt <= cnt + 1'b1;
            end
            if (last_beat) begin
                valid[idx] <= ~(inv_pend | invalidate);
            end
            if (invalidate) begin
                valid <= '0;
                if (state == MISS_REQ || state == REFILL) begin
                    inv_pend <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_resp_valid) begin
            data_mem[idx][cnt] <= mem_resp_data;
        end
        if (last_beat) begin
            tag_mem[idx] <= req_tag;
        end
    end

    // Registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            icache_req_ready    <= 1'b1;
            icache_resp_valid   <= 1'b0;
            mem_req_valid       <= 1'b0;
            mem_req_addr        <= '0;
            fetch_data          <= '0;
            icache_resp_address <= '0;
        end else begin
            icache_req_ready  <= (state_nx == IDLE);
            icache_resp_valid <= (state_nx == RESP);
            mem_req_valid     <= (state_nx == MISS_REQ);
            if (state == LOOKUP && !hit) begin
                mem_req_addr <= {req_addr[31:LINE_LSB], LINE_LSB'(0)};
            end
            if (state != RESP && state_nx == RESP) begin
                fetch_data          <= resp_word;
                icache_resp_address <= req_addr;
            end
        end
    end

endmodule
